// File: rtl/md_pkg.sv
// Shared constants and FSM state encoding for the EX-stage multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_DIV_LAT = MD_WIDTH + 2;

  typedef logic [1:0] md_state_t;

  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_CALC = 2'd1;
  localparam md_state_t ST_FIX  = 2'd2;
  localparam md_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The shifted partial remainder needs one extra bit, since it can reach 2*dvs-1.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_shift = {rem, dvd_msb};
    diff      = rem_shift - {1'b0, dvs};
    q_bit     = (rem_shift >= {1'b0, dvs});
    rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/md_iter_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// with a final sign-fix cycle before the done pulse.
module md_iter_div
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] q;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  // Negating MIN wraps back to MIN, which read as unsigned is exactly |MIN|.
  assign sa           = is_signed & dividend[WIDTH-1];
  assign sb           = is_signed & divisor[WIDTH-1];
  assign dividend_mag = sa ? -dividend : dividend;
  assign divisor_mag  = sb ? -divisor  : divisor;

  md_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // the working registers are reset too, keeping the block free of X after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      q         <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_div  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      // Flush: results from the last completed op stay visible.
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          div0 <= 1'b0;
          if (start) begin
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            dvs      <= divisor_mag;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            busy     <= 1'b1;
            zero_div <= (divisor == '0);
            if (divisor == '0) begin
              // Raw dividend is kept so FIX can return it unmodified.
              dvd   <= dividend;
              state <= ST_FIX;
            end else begin
              dvd   <= dividend_mag;
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_CALC: begin
          rem <= rem_next;
          dvd <= dvd << 1;
          q   <= {q[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end

        ST_FIX: begin
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dvd;
            div0      <= 1'b1;
          end else begin
            quotient  <= neg_q ? -q   : q;
            remainder <= neg_r ? -rem : rem;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_iter_div.sv
// Directed self-checking bench for md_iter_div (WIDTH=32).
module tb_md_iter_div;
  import md_pkg::*;

  localparam int W   = MD_WIDTH;
  localparam int LAT = MD_DIV_LAT - 1;  // edges from the accepting edge to done

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic         abort;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div0;

  int n_tests = 0;
  int n_fail  = 0;

  md_iter_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .abort     (abort),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  // Drive a request for one edge, then scramble the operands.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0000;
    is_signed = ~sgn;
  endtask

  // Returns the edge count until done, or 0 if max edges pass without it.
  task automatic wait_done(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0: got %b expected 0", div0); end
    n_tests++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", quotient); end
    n_tests++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", remainder); end
  endtask

  task automatic test_divu_basic;
    int n;
    issue(1'b0, 32'd100, 32'd7);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL divu_busy_start: got %b expected 1", busy); end
    wait_done(LAT + 5, n);
    n_tests++; if (n !== LAT) begin n_fail++; $display("FAIL divu_latency: got %0d expected %0d", n, LAT); end
    n_tests++; if (quotient !== 32'h0000_000E) begin n_fail++; $display("FAIL divu_q: got %h expected 0000000e", quotient); end
    n_tests++; if (remainder !== 32'h0000_0002) begin n_fail++; $display("FAIL divu_r: got %h expected 00000002", remainder); end
    n_tests++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL divu_div0: got %b expected 0", div0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divu_busy_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL divu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_signed;
    int n;
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(LAT + 5, n);
    n_tests++; if (n !== LAT) begin n_fail++; $display("FAIL div_neg_latency: got %0d expected %0d", n, LAT); end
    n_tests++; if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_q: got %h expected fffffffd", quotient); end
    n_tests++; if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_r: got %h expected ffffffff", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_min_neg1;
    int n;
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(LAT + 5, n);
    n_tests++; if (n !== LAT) begin n_fail++; $display("FAIL min_latency: got %0d expected %0d", n, LAT); end
    n_tests++; if (quotient !== 32'h8000_0000) begin n_fail++; $display("FAIL min_q: got %h expected 80000000", quotient); end
    n_tests++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL min_r: got %h expected 00000000", remainder); end
    @(posedge clk); #1;
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(LAT + 5, n);
    n_tests++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL minu_q: got %h expected 00000000", quotient); end
    n_tests++; if (remainder !== 32'h8000_0000) begin n_fail++; $display("FAIL minu_r: got %h expected 80000000", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div0;
    int n;
    issue(1'b1, 32'hFFFF_FFF9, 32'h0);
    wait_done(LAT + 5, n);
    n_tests++; if (n !== 1) begin n_fail++; $display("FAIL div0s_latency: got %0d expected 1", n); end
    n_tests++; if (remainder !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL div0s_r_raw: got %h expected fffffff9", remainder); end
    @(posedge clk); #1;
    issue(1'b0, 32'h1234_5678, 32'h0);
    wait_done(LAT + 5, n);
    n_tests++; if (n !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d expected 1", n); end
    n_tests++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_q: got %h expected ffffffff", quotient); end
    n_tests++; if (remainder !== 32'h1234_5678) begin n_fail++; $display("FAIL div0_r: got %h expected 12345678", remainder); end
    n_tests++; if (div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag: got %b expected 1", div0); end
    @(posedge clk); #1;
    n_tests++; if ({done, div0} !== 2'b00) begin n_fail++; $display("FAIL div0_clear: got %b expected 00", {done, div0}); end
  endtask

  task automatic test_abort;
    int n;
    issue(1'b0, 32'd50, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_tests++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL abort_q_hold: got %h expected ffffffff", quotient); end
    n_tests++; if (remainder !== 32'h1234_5678) begin n_fail++; $display("FAIL abort_r_hold: got %h expected 12345678", remainder); end
    wait_done(LAT + 5, n);
    n_tests++; if (n !== 0) begin n_fail++; $display("FAIL abort_no_done: got done after %0d edges expected none", n); end
    // Abort together with start must not accept anything.
    abort = 1'b1; start = 1'b1; is_signed = 1'b0; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_busy: got %b expected 0", busy); end
    issue(1'b0, 32'd9, 32'd3);
    wait_done(LAT + 5, n);
    n_tests++; if (n !== LAT) begin n_fail++; $display("FAIL post_abort_latency: got %0d expected %0d", n, LAT); end
    n_tests++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL post_abort_q: got %h expected 00000003", quotient); end
    n_tests++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL post_abort_r: got %h expected 00000000", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    int n2;
    issue(1'b0, 32'd1000, 32'd10);
    repeat (4) @(posedge clk);
    #1;
    // Start pulsed mid-CALC must be ignored.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd5; divisor = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(LAT + 5, n);
    n_tests++; if (n + 5 !== LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", n + 5, LAT); end
    n_tests++; if (quotient !== 32'd100) begin n_fail++; $display("FAIL b2b_first_q: got %h expected 00000064", quotient); end
    n_tests++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_first_r: got %h expected 00000000", remainder); end
    // Now in the DONE cycle: this start is accepted with no bubble.
    issue(1'b1, 32'hFFFF_FFEC, 32'd3);
    wait_done(LAT + 5, n2);
    n_tests++; if (n2 + 1 !== LAT + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", n2 + 1, LAT + 1); end
    n_tests++; if (quotient !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL b2b_second_q: got %h expected fffffffa", quotient); end
    n_tests++; if (remainder !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_second_r: got %h expected fffffffe", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    issue(1'b0, 32'd1, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 00", {busy, done}); end
    n_tests++; if (quotient !== '0) begin n_fail++; $display("FAIL rst_mid_q: got %h expected 00000000", quotient); end
    n_tests++; if (remainder !== '0) begin n_fail++; $display("FAIL rst_mid_r: got %h expected 00000000", remainder); end
  endtask

  initial begin
    test_reset;
    test_divu_basic;
    test_signed;
    test_min_neg1;
    test_div0;
    test_abort;
    test_back_to_back;
    test_reset_mid_op;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
